// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: sequential PC generation, in-order imem requests,
// prefetch queue feeding IF/ID, and redirect-driven flush with in-flight drop.
module instr_fetch_unit #(
    parameter int              PC_W     = 9,
    parameter int              INS_W    = 32,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [INS_W-1:0] imem_rdata,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    input  logic             id_ready,
    output logic             id_valid,
    output logic [INS_W-1:0] id_instr,
    output logic [PC_W-1:0]  id_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PC_W-1:0]  PC_STEP   = PC_W'(4);
    localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(DEPTH);

    typedef struct packed {
        logic [INS_W-1:0] instr;
        logic [PC_W-1:0]  pc;
    } entry_t;

    entry_t             queue [DEPTH];
    entry_t             head;
    logic [PC_W-1:0]    fetch_pc;
    logic [PC_W-1:0]    resp_pc;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   drop_cnt;
    logic [CNT_W:0]     committed;
    logic               fire;
    logic               push;
    logic               pop;
    logic               empty;
    logic               dropping;

    // Queued plus in-flight entries never exceed DEPTH, so a returning
    // response always finds a free slot.
    assign committed = {1'b0, count} + {1'b0, outstanding};
    assign imem_req  = !rst && !redirect && (committed < DEPTH_EXT);
    assign imem_addr = fetch_pc;
    assign fire      = imem_req && imem_gnt;

    assign dropping  = (drop_cnt != '0);
    assign push      = imem_rvalid && !dropping && !redirect;

    assign empty     = (count == '0);
    assign id_valid  = !empty && !redirect;
    assign pop       = id_valid && id_ready;

    assign head      = queue[rd_ptr];
    assign id_instr  = id_valid ? head.instr : '0;
    assign id_pc     = id_valid ? head.pc    : '0;

    // Payload storage carries no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push)
            queue[wr_ptr] <= entry_t'{instr: imem_rdata, pc: resp_pc};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect) begin
            // Every response still owed by memory belongs to the old path,
            // including ones already marked for dropping.
            fetch_pc    <= redirect_pc;
            resp_pc     <= redirect_pc;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= outstanding - CNT_W'(imem_rvalid);
            drop_cnt    <= outstanding - CNT_W'(imem_rvalid);
        end else begin
            if (fire)
                fetch_pc <= fetch_pc + PC_STEP;
            if (push) begin
                wr_ptr  <= wr_ptr + PTR_W'(1);
                resp_pc <= resp_pc + PC_STEP;
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count       <= count + CNT_W'(push) - CNT_W'(pop);
            outstanding <= outstanding + CNT_W'(fire) - CNT_W'(imem_rvalid);
            if (imem_rvalid && dropping)
                drop_cnt <= drop_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order memory model whose
// responses can be held back to create in-flight requests.
module tb_instr_fetch_unit;

    localparam int PC_W  = 9;
    localparam int INS_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_gnt;
    logic             imem_rvalid;
    logic [INS_W-1:0] imem_rdata;
    logic             redirect;
    logic [PC_W-1:0]  redirect_pc;
    logic             id_ready;
    logic             id_valid;
    logic [INS_W-1:0] id_instr;
    logic [PC_W-1:0]  id_pc;
    logic             mem_hold;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(4), .RESET_PC('0)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc)
    );

    // In-order memory: a granted address may return the very next cycle;
    // mem_hold keeps responses queued.
    logic [PC_W-1:0] mf [16];
    logic [3:0]      wp, rp;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
        end else begin
            if (imem_req && imem_gnt) begin
                mf[wp] <= imem_addr;
                wp <= wp + 4'd1;
            end
            if (!mem_hold && (wp != rp || (imem_req && imem_gnt))) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= 32'hA000_0000 | 32'(wp != rp ? mf[rp] : imem_addr);
                rp <= rp + 4'd1;
            end else begin
                imem_rvalid <= 1'b0;
            end
        end
    end

    function automatic logic [63:0] ins(input int pc);
        return 64'(32'hA000_0000 | pc);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_gnt = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b1;
        mem_hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        imem_gnt = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b1;
        mem_hold = 1'b0;
        #2;
        chk("rst_req",   imem_req,  0);
        chk("rst_addr",  imem_addr, 0);
        chk("rst_valid", id_valid,  0);
        chk("rst_instr", id_instr,  0);
        chk("rst_pc",    id_pc,     0);

        // 1: streaming from reset, one instruction per cycle
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t1_req0",  imem_req,  1);
        chk("t1_addr0", imem_addr, 0);
        @(negedge clk);
        chk("t1_addr1",  imem_addr, 4);
        chk("t1_valid1", id_valid,  0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t1_valid", id_valid,  1);
            chk("t1_pc",    id_pc,     64'(4 * i));
            chk("t1_instr", id_instr,  ins(4 * i));
            chk("t1_addr",  imem_addr, 64'(8 + 4 * i));
        end

        // 2: ID stall fills the queue, then drains in order
        do_reset();
        id_ready = 1'b0;
        repeat (10) @(negedge clk);
        chk("t2_req_full", imem_req,  0);
        chk("t2_addr",     imem_addr, 16);
        chk("t2_valid",    id_valid,  1);
        chk("t2_head",     id_pc,     0);
        id_ready = 1'b1;
        #1;
        chk("t2_pc0", id_pc, 0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("t2_dvalid", id_valid, 1);
            chk("t2_dpc",    id_pc,    64'(4 * i));
            chk("t2_dinstr", id_instr, ins(4 * i));
            if (i == 1) begin
                chk("t2_resume_req",  imem_req,  1);
                chk("t2_resume_addr", imem_addr, 16);
            end
        end

        // 3: redirect with two responses held in memory
        do_reset();
        mem_hold = 1'b1;
        @(negedge clk);
        @(negedge clk);
        imem_gnt = 1'b0;
        chk("t3_addr8", imem_addr, 8);
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 9'h040;
        imem_gnt = 1'b1;
        mem_hold = 1'b0;
        #1;
        chk("t3_req_redir",   imem_req, 0);
        chk("t3_valid_redir", id_valid, 0);
        chk("t3_pc_redir",    id_pc,    0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("t3_addr_tgt", imem_addr, 9'h040);
        chk("t3_req_tgt",  imem_req,  1);
        chk("t3_valid_e",  id_valid,  0);
        @(negedge clk);
        chk("t3_valid_f", id_valid, 0);
        @(negedge clk);
        chk("t3_valid_g", id_valid, 0);
        @(negedge clk);
        chk("t3_valid_h", id_valid, 1);
        chk("t3_pc_h",    id_pc,    9'h040);
        chk("t3_instr_h", id_instr, ins(9'h040));
        @(negedge clk);
        chk("t3_pc_next", id_pc, 9'h044);

        // 4: redirect coincident with rvalid and pop
        do_reset();
        @(negedge clk);
        @(negedge clk);
        chk("t4_valid_pre", id_valid, 1);
        chk("t4_pc_pre",    id_pc,    0);
        chk("t4_rvalid",    imem_rvalid, 1);
        redirect = 1'b1;
        redirect_pc = 9'h100;
        #1;
        chk("t4_valid_redir", id_valid, 0);
        chk("t4_req_redir",   imem_req, 0);
        chk("t4_instr_redir", id_instr, 0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("t4_empty",    id_valid,  0);
        chk("t4_addr_tgt", imem_addr, 9'h100);
        chk("t4_req_tgt",  imem_req,  1);
        @(negedge clk);
        chk("t4_no_stale", id_valid, 0);
        @(negedge clk);
        chk("t4_valid_tgt", id_valid, 1);
        chk("t4_pc_tgt",    id_pc,    9'h100);

        // 5: PC wrap at 2**PC_W
        do_reset();
        redirect = 1'b1;
        redirect_pc = 9'h1F8;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("t5_addr_1f8", imem_addr, 9'h1F8);
        @(negedge clk);
        chk("t5_addr_1fc", imem_addr, 9'h1FC);
        @(negedge clk);
        chk("t5_addr_wrap", imem_addr, 0);
        chk("t5_pc_1f8",    id_pc,     9'h1F8);
        @(negedge clk);
        chk("t5_pc_1fc", id_pc,     9'h1FC);
        chk("t5_addr_4", imem_addr, 4);
        @(negedge clk);
        chk("t5_pc_wrap",    id_pc,    0);
        chk("t5_instr_wrap", id_instr, ins(0));

        // 6: reset with queued entries and requests in flight
        do_reset();
        id_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mem_hold = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t6_req_busy", imem_req, 0);
        chk("t6_valid",    id_valid, 1);
        chk("t6_pc",       id_pc,    0);
        rst = 1'b1;
        #1;
        chk("t6_rst_req",   imem_req,  0);
        chk("t6_rst_addr",  imem_addr, 0);
        chk("t6_rst_valid", id_valid,  0);
        chk("t6_rst_instr", id_instr,  0);
        chk("t6_rst_pc",    id_pc,     0);
        @(negedge clk);
        rst = 1'b0;
        mem_hold = 1'b0;
        id_ready = 1'b1;
        #1;
        chk("t6_post_req",  imem_req,  1);
        chk("t6_post_addr", imem_addr, 0);
        @(negedge clk);
        @(negedge clk);
        chk("t6_post_valid", id_valid, 1);
        chk("t6_post_pc",    id_pc,    0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
